// File: rtl/debouncer_pkg.sv
// Shared defaults and helpers for the button debouncer and its benches.
package debouncer_pkg;

    localparam int DEFAULT_COUNTER_BITS = 20;
    localparam int DEFAULT_SYNC_STAGES  = 2;

    // Cycles the synchronized input must hold a new level before it is accepted.
    function automatic longint unsigned stable_cycles(input int unsigned counter_bits);
        return 64'd1 << counter_bits;
    endfunction

endpackage

// File: rtl/debouncer_sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debounces one bouncy input into a clean level plus single-cycle rise/fall pulses.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic input_unstable,
    output logic output_stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic                    sync_in;
    logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic                    out_q, out_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (input_unstable),
        .q     (sync_in)
    );

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (sync_in == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            // Full stable window seen: accept the level and clear, so the counter never wraps.
            out_d = sync_in;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Pulses are formed from the next output against the current one so they
        // line up with the cycle output_stable first shows its new value.
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign output_stable = out_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer with COUNTER_BITS=4, SYNC_STAGES=2, 10 ns clock.
module tb_debouncer;
    import debouncer_pkg::*;

    localparam int CB = 4;
    localparam int SS = 2;

    logic clk;
    logic rst_n;
    logic input_unstable;
    logic output_stable;
    logic rise_pulse;
    logic fall_pulse;

    int tests;
    int errors;
    int rise_cnt;
    int fall_cnt;
    int both_cnt;
    int lat_nom;
    int lat;
    int r0;
    int f0;

    debouncer #(
        .COUNTER_BITS (CB),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .input_unstable (input_unstable),
        .output_stable  (output_stable),
        .rise_pulse     (rise_pulse),
        .fall_pulse     (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse outputs only move on posedge, so negedge sampling is race-free.
    always @(negedge clk) begin
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
        if (rise_pulse && fall_pulse) both_cnt++;
    end

    task automatic check(input string tag, input int observed, input int expected);
        tests++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive a level at a negedge and hold it for n rising edges.
    task automatic hold(input logic v, input int n);
        @(negedge clk);
        input_unstable = v;
        repeat (n) @(posedge clk);
    endtask

    // Count rising edges until output_stable reaches v; returns max+1 on timeout.
    task automatic wait_out(input logic v, input int max, output int n);
        n = 0;
        while (n <= max) begin
            @(posedge clk);
            #1;
            n++;
            if (output_stable === v) break;
        end
    endtask

    task automatic check_lat(input string tag, input int l);
        check(tag, int'(l >= lat_nom - 1 && l <= lat_nom + 1), 1);
    endtask

    initial begin
        tests    = 0;
        errors   = 0;
        rise_cnt = 0;
        fall_cnt = 0;
        both_cnt = 0;
        lat_nom  = SS + int'(stable_cycles(CB));
        rst_n          = 1'b0;
        input_unstable = 1'b1;

        // Reset held with input high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", int'(output_stable), 0);
        check("rst_rise", int'(rise_pulse), 0);
        check("rst_fall", int'(fall_pulse), 0);
        check("rst_cnt", int'(dut.cnt_q), 0);

        // Release with the input already high: full latency to rise.
        r0 = rise_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        wait_out(1'b1, 40, lat);
        check_lat("rst_release_lat", lat);
        hold(1'b1, 3);
        check("rst_release_rise", rise_cnt - r0, 1);

        // Return to 0 before the bounce test.
        f0 = fall_cnt;
        hold(1'b0, 0);
        wait_out(1'b0, 40, lat);
        check_lat("init_fall_lat", lat);
        hold(1'b0, 3);
        check("init_fall_pulse", fall_cnt - f0, 1);

        // Bounce rejection.
        r0 = rise_cnt;
        f0 = fall_cnt;
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
        hold(1'b1, 3); hold(1'b0, 1);
        hold(1'b0, 25);
        #1;
        check("bounce_out", int'(output_stable), 0);
        check("bounce_rise", rise_cnt - r0, 0);
        check("bounce_fall", fall_cnt - f0, 0);

        // Stable press.
        r0 = rise_cnt;
        f0 = fall_cnt;
        hold(1'b1, 0);
        wait_out(1'b1, 40, lat);
        check_lat("press_lat", lat);
        hold(1'b1, 5);
        #1;
        check("press_out", int'(output_stable), 1);
        check("press_rise", rise_cnt - r0, 1);
        check("press_fall", fall_cnt - f0, 0);

        // Stable release.
        r0 = rise_cnt;
        f0 = fall_cnt;
        hold(1'b0, 0);
        wait_out(1'b0, 40, lat);
        check_lat("release_lat", lat);
        hold(1'b0, 5);
        #1;
        check("release_out", int'(output_stable), 0);
        check("release_fall", fall_cnt - f0, 1);
        check("release_rise", rise_cnt - r0, 0);

        // Near threshold: 15 cycles high is one short of the window.
        r0 = rise_cnt;
        hold(1'b1, 15);
        hold(1'b0, 25);
        #1;
        check("glitch15_out", int'(output_stable), 0);
        check("glitch15_rise", rise_cnt - r0, 0);
        hold(1'b1, 0);
        wait_out(1'b1, 40, lat);
        check_lat("long_high_lat", lat);
        hold(1'b1, 2);
        check("long_high_rise", rise_cnt - r0, 1);
        hold(1'b0, 0);
        wait_out(1'b0, 40, lat);
        check_lat("long_high_fall_lat", lat);
        hold(1'b0, 3);

        // Mid-count reset: counter and output clear at once, count restarts.
        r0 = rise_cnt;
        hold(1'b1, 10);
        #1;
        check("mid_cnt_before", int'(dut.cnt_q != 0), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_cnt_async", int'(dut.cnt_q), 0);
        check("mid_out_async", int'(output_stable), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_out(1'b1, 40, lat);
        check_lat("mid_reset_lat", lat);

        // Input stuck high: no further pulses.
        hold(1'b1, 2);
        r0 = rise_cnt;
        f0 = fall_cnt;
        hold(1'b1, 40);
        #1;
        check("stuck_out", int'(output_stable), 1);
        check("stuck_rise", rise_cnt - r0, 0);
        check("stuck_fall", fall_cnt - f0, 0);
        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
